// File: rtl/priority_arbiter_8_pkg.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8_pkg
//   Shared definitions for the 8-requester priority arbiter: FSM state
//   encoding, requester count / id width, and the request-rotation helper
//   used when rotating priority is built in (macro ROUND_ROBIN_EN).
// -----------------------------------------------------------------------------
package priority_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Rotates the request vector so that req[amt-1] lands on bit 7 (highest
  // priority in the pick) and req[amt] lands on bit 0 (lowest). The 3-bit
  // index addition wraps modulo 8 by construction.
  function automatic logic [NUM_REQ-1:0] rotate_req(input logic [NUM_REQ-1:0] req,
                                                    input logic [ID_W-1:0]    amt);
    logic [NUM_REQ-1:0] rot;
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[ID_W'(k) + amt];
    end
    return rot;
  endfunction

endpackage

// File: rtl/priority_arbiter_8_if.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8_if
//   Client-side bundle of the arbiter.
//     en       : arbitration enable (low = no new grants)
//     req[7:0] : request lines, held high by a client while it wants/uses
//                the resource
//     gnt[7:0] : one-hot registered grant, zero when nothing is granted
//     gnt_id   : binary index of the granted client, 0 when gnt_vld=0
//     gnt_vld  : high while a grant is active (== |gnt)
//     timeout  : one-cycle pulse when a grant is revoked by the hold limit
//   master : client side (drives en/req)
//   slave  : arbiter side (drives the grant outputs)
// -----------------------------------------------------------------------------
interface priority_arbiter_8_if;
  import priority_arbiter_8_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic               timeout;

  modport master (output en, req, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input en, req, output gnt, gnt_id, gnt_vld, timeout);

endinterface

// File: rtl/priority_arbiter_8_prio_pick.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8_prio_pick
//   Combinational 8:3 priority pick, index 7 highest.
//     req_i[7:0] : candidate request vector
//     id_o[2:0]  : index of the highest set bit (0 when none set)
//     vld_o      : at least one bit set
// -----------------------------------------------------------------------------
module priority_arbiter_8_prio_pick
  import priority_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output logic [ID_W-1:0]    id_o,
  output logic               vld_o
);

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    id_o = '0;
    // Ascending scan: a later (higher) set bit overwrites a lower one.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/priority_arbiter_8.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8
//   8-requester resource arbiter. Grants one client at a time, holds the grant
//   until the client drops its request or MAX_HOLD grant cycles elapse, then
//   inserts one dead (GAP) cycle before re-arbitrating.
//
//   Ports:
//     clk   : system clock, rising-edge
//     rst_n : asynchronous active-low reset
//     bus   : priority_arbiter_8_if.slave (en, req in; gnt, gnt_id, gnt_vld,
//             timeout out)
//   Parameter:
//     MAX_HOLD : max consecutive grant cycles, 0 = unlimited, legal 0..255
//   Build option:
//     ROUND_ROBIN_EN defined  -> rotating priority, (last_id-1) highest and
//                                the last released id lowest
//     ROUND_ROBIN_EN undefined -> fixed priority, req[7] highest
// -----------------------------------------------------------------------------
module priority_arbiter_8
  import priority_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  priority_arbiter_8_if.slave   bus
);

  localparam bit       TIMEOUT_EN = (MAX_HOLD != 0);
  localparam bit [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e             state_q,    state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]    last_id_q,  last_id_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [ID_W-1:0]    gnt_id_q,   gnt_id_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;
  logic [ID_W-1:0]    win_id;
  logic               cur_req;
  logic               hold_last;

  // ---------------------------------------------------------------------------
  // Priority selection. Rotating priority reuses the fixed pick by rotating
  // the request vector in and adding the rotation back onto the result.
  // ---------------------------------------------------------------------------
`ifdef ROUND_ROBIN_EN
  assign pick_req = rotate_req(bus.req, last_id_q);
  assign win_id   = pick_id + last_id_q;
`else
  assign pick_req = bus.req;
  assign win_id   = pick_id;
  // last_id is still tracked so both builds share one state machine.
  logic last_id_unused;
  assign last_id_unused = ^last_id_q;
`endif

  priority_arbiter_8_prio_pick u_pick (
    .req_i (pick_req),
    .id_o  (pick_id),
    .vld_o (pick_vld)
  );

  assign cur_req   = bus.req[gnt_id_q];
  assign hold_last = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic. Grant outputs are computed here and registered, so a
  // grant appears one cycle after the request is seen and drops on the
  // transition into GAP.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        if (bus.en && pick_vld) begin
          state_d    = ST_GRANT;
          gnt_d      = NUM_REQ'(1) << win_id;
          gnt_id_d   = win_id;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Saturate so an unlimited hold (MAX_HOLD=0) never wraps.
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        // Release wins over timeout when both happen in the same cycle;
        // en is deliberately ignored here so a grant is never cut short.
        if (!cur_req || hold_last) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          gnt_id_d  = '0;
          last_id_d = gnt_id_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_id_q  <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = |gnt_q;
  // The pulse marks the final granted cycle itself, so it is decoded from the
  // live request rather than registered (a registered pulse would land in GAP).
  assign bus.timeout = (state_q == ST_GRANT) && cur_req && hold_last;

endmodule
